// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converters.
package bcd_pkg;

  // Largest legal BCD digit, correction threshold and correction amount.
  localparam int BCD_MAX_DIGIT  = 9;
  localparam int BCD_ADJ_THRESH = 8;
  localparam int BCD_ADJ_VAL    = 3;

  // Converter FSM encoding.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_SUB   = 2'd2
  } bcd_state_e;

  // Minimum binary width able to hold 10^n_digits - 1.
  function automatic int bcd_bin_width(input int n_digits);
    longint unsigned max_val;
    int w;
    max_val = 1;
    w = 1;
    for (int i = 0; i < n_digits; i++) begin
      max_val = max_val * 10;
    end
    max_val = max_val - 1;
    while ((max_val >> w) != 0) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bin_from_bcd.sv
// Serial BCD-to-binary converter (reverse double dabble).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | collect digits into slots; MSD strobe starts a conversion
// S_SHIFT | shift {digits, bin} right by one; last shift publishes result
// S_SUB   | correct one digit per cycle (>= 8 -> minus 3), walking LSD..MSD
module bin_from_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_VAL_WIDTH = 14,
  parameter int DEC_DIGITS    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               digit_i,
  input  logic [DEC_DIGITS-1:0]    digit_strb_i,
  output logic                     ready_o,
  output logic [BIN_VAL_WIDTH-1:0] bin_val_o,
  output logic                     valid_o,
  output logic                     err_o
);

  localparam int SR_W = DEC_DIGITS * 4 + BIN_VAL_WIDTH;
  localparam int LC_W = $clog2(BIN_VAL_WIDTH);
  localparam int DI_W = $clog2(DEC_DIGITS);
  localparam logic [LC_W-1:0] LOOP_LAST  = LC_W'(BIN_VAL_WIDTH - 1);
  localparam logic [DI_W-1:0] DIGIT_LAST = DI_W'(DEC_DIGITS - 1);

  // Reject parameter sets where the result cannot hold every decimal value.
  if (BIN_VAL_WIDTH < bcd_bin_width(DEC_DIGITS) || BIN_VAL_WIDTH < 2 || DEC_DIGITS < 2) begin : g_bad_param
    $error("bin_from_bcd: BIN_VAL_WIDTH too small for DEC_DIGITS");
  end

  bcd_state_e               state_q, state_d;
  logic [SR_W-1:0]          sr_q, sr_d;
  logic [LC_W-1:0]          loop_cnt_q, loop_cnt_d;
  logic [DI_W-1:0]          digit_idx_q, digit_idx_d;
  logic                     err_q, err_d;
  logic [BIN_VAL_WIDTH-1:0] bin_val_q, bin_val_d;
  logic                     valid_q, valid_d;
  logic                     err_out_q, err_out_d;

  logic [SR_W-1:0] shifted;
  logic [3:0]      cur_dig;
  logic            fin_err;
  int              dig_base;

  // Next-state, datapath and result computation.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    loop_cnt_d  = loop_cnt_q;
    digit_idx_d = digit_idx_q;
    err_d       = err_q;
    bin_val_d   = bin_val_q;
    valid_d     = 1'b0;
    err_out_d   = err_out_q;
    shifted     = sr_q >> 1;
    dig_base    = BIN_VAL_WIDTH + 4 * int'(digit_idx_q);
    cur_dig     = sr_q[dig_base +: 4];
    fin_err     = err_q | (|shifted[SR_W-1:BIN_VAL_WIDTH]);

    case (state_q)
      S_IDLE: begin
        for (int k = 0; k < DEC_DIGITS; k++) begin
          if (digit_strb_i[k]) begin
            sr_d[BIN_VAL_WIDTH + 4 * k +: 4] = digit_i;
          end
        end
        if (|digit_strb_i) begin
          if (!$onehot(digit_strb_i)) err_d = 1'b1;
          if (digit_i > 4'(BCD_MAX_DIGIT)) err_d = 1'b1;
        end
        if (digit_strb_i[DEC_DIGITS-1]) begin
          sr_d[BIN_VAL_WIDTH-1:0] = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sr_d = shifted;
        if (loop_cnt_q == LOOP_LAST) begin
          // Leftover digit bits mean the input was not valid BCD.
          loop_cnt_d = '0;
          bin_val_d  = fin_err ? '0 : shifted[BIN_VAL_WIDTH-1:0];
          err_out_d  = fin_err;
          valid_d    = 1'b1;
          sr_d[SR_W-1:BIN_VAL_WIDTH] = '0;
          err_d      = 1'b0;
          state_d    = S_IDLE;
        end else begin
          loop_cnt_d = loop_cnt_q + LC_W'(1);
          state_d    = S_SUB;
        end
      end

      S_SUB: begin
        if (cur_dig >= 4'(BCD_ADJ_THRESH)) begin
          sr_d[dig_base +: 4] = cur_dig - 4'(BCD_ADJ_VAL);
        end
        if (digit_idx_q == DIGIT_LAST) begin
          digit_idx_d = '0;
          state_d     = S_SHIFT;
        end else begin
          digit_idx_d = digit_idx_q + DI_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      loop_cnt_q  <= '0;
      digit_idx_q <= '0;
      err_q       <= 1'b0;
      bin_val_q   <= '0;
      valid_q     <= 1'b0;
      err_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      loop_cnt_q  <= loop_cnt_d;
      digit_idx_q <= digit_idx_d;
      err_q       <= err_d;
      bin_val_q   <= bin_val_d;
      valid_q     <= valid_d;
      err_out_q   <= err_out_d;
    end
  end

  assign ready_o   = (state_q == S_IDLE);
  assign bin_val_o = bin_val_q;
  assign valid_o   = valid_q;
  assign err_o     = err_out_q;

endmodule

// File: tb/tb_bin_from_bcd.sv
// Directed bench for bin_from_bcd with hand-computed results.
module tb_bin_from_bcd;

  localparam int W = 14;
  localparam int D = 4;
  localparam int LATENCY = W + (W - 1) * D + 1;  // 67

  logic         clk;
  logic         rst;
  logic [3:0]   digit_i;
  logic [D-1:0] digit_strb_i;
  logic         ready_o;
  logic [W-1:0] bin_val_o;
  logic         valid_o;
  logic         err_o;

  int n_tests;
  int n_fail;

  bin_from_bcd #(.BIN_VAL_WIDTH(W), .DEC_DIGITS(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .digit_i      (digit_i),
    .digit_strb_i (digit_strb_i),
    .ready_o      (ready_o),
    .bin_val_o    (bin_val_o),
    .valid_o      (valid_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold one strobe/digit for one clock (set at negedge, sampled next posedge).
  task automatic drive(input logic [D-1:0] strb, input logic [3:0] d);
    @(negedge clk);
    digit_strb_i = strb;
    digit_i      = d;
  endtask

  // Wait for the result after the MSD strobe; optionally flood ignored strobes.
  task automatic wait_result(input string tag, input logic [W-1:0] exp_val,
                             input logic exp_err, input bit flood);
    int cycles;
    cycles = 0;
    while (cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (valid_o) begin
        digit_strb_i = '0;
        break;
      end
      if (flood) begin
        digit_strb_i = 4'hF;
        digit_i      = 4'd9;
        if (cycles == 10) chk({tag, "_busy_ready"}, 32'(ready_o), 32'd0);
      end else begin
        digit_strb_i = '0;
      end
    end
    chk({tag, "_latency"}, 32'(cycles), 32'(LATENCY));
    chk({tag, "_val"},     32'(bin_val_o), 32'(exp_val));
    chk({tag, "_err"},     32'(err_o), 32'(exp_err));
    chk({tag, "_ready"},   32'(ready_o), 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"},   32'(valid_o), 32'd0);
  endtask

  // Send four digits LSD first with optional idle gaps, then check.
  task automatic run_conv(input string tag, input logic [15:0] digs, input int gap,
                          input logic [W-1:0] exp_val, input logic exp_err, input bit flood);
    for (int k = 0; k < D; k++) begin
      drive(D'(1 << k), digs[4*k +: 4]);
      if (k < D - 1) begin
        for (int g = 0; g < gap; g++) drive('0, 4'd0);
      end
    end
    wait_result(tag, exp_val, exp_err, flood);
  endtask

  initial begin
    int vcount;
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    digit_i      = '0;
    digit_strb_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_val",   32'(bin_val_o), 32'd0);
    chk("rst_err",   32'(err_o), 32'd0);

    run_conv("c1234", 16'h1234, 0, 14'h04D2, 1'b0, 1'b0);
    run_conv("c9999", 16'h9999, 0, 14'h270F, 1'b0, 1'b0);
    run_conv("c0000", 16'h0000, 0, 14'h0000, 1'b0, 1'b0);

    // Invalid digit 0xA in slot 1.
    drive(4'b0001, 4'd0);
    drive(4'b0010, 4'hA);
    drive(4'b0100, 4'd0);
    drive(4'b1000, 4'd0);
    wait_result("badA", 14'h0000, 1'b1, 1'b0);
    run_conv("after_err", 16'h0005, 0, 14'd5, 1'b0, 1'b0);

    // Multi-bit strobe.
    drive(4'b0011, 4'd2);
    drive(4'b0100, 4'd0);
    drive(4'b1000, 4'd0);
    wait_result("multi", 14'h0000, 1'b1, 1'b0);

    run_conv("flood", 16'h4567, 0, 14'h11D7, 1'b0, 1'b1);
    run_conv("gap3",  16'h4567, 3, 14'h11D7, 1'b0, 1'b0);

    // Reset in the middle of a conversion.
    for (int k = 0; k < D; k++) drive(D'(1 << k), 4'(k + 2));
    @(negedge clk);
    digit_strb_i = '0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready_o), 32'd1);
    chk("abort_val",   32'(bin_val_o), 32'd0);
    chk("abort_err",   32'(err_o), 32'd0);
    vcount = 0;
    repeat (80) begin
      @(negedge clk);
      if (valid_o) vcount++;
    end
    chk("abort_novalid", 32'(vcount), 32'd0);
    run_conv("post_abort", 16'h0001, 0, 14'd1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
